// File: rtl/asteroid_pkg.sv
// Shared definitions for the asteroid field engine: frame FSM encoding,
// spawn velocity field layout and step sizes.
package asteroid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UPD_X = 3'd1,
    ST_UPD_Y = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // spawn_vel = {sub_x, spd_x, sub_y, spd_y}
  localparam int VEL_SUB_X = 3;
  localparam int VEL_SPD_X = 2;
  localparam int VEL_SUB_Y = 1;
  localparam int VEL_SPD_Y = 0;

  localparam int STEP_SMALL = 1;
  localparam int STEP_LARGE = 2;

endpackage

// File: rtl/lives_counter.sv
// Lives counter: synchronous load of the starting value, saturating
// decrement, and a zero flag used as the game-over indication.
module lives_counter #(
  parameter int LIVES_W    = 2,
  parameter int INIT_LIVES = 3
) (
  input  logic               clock_i,
  input  logic               clear_i,
  input  logic               dec_i,
  output logic [LIVES_W-1:0] count_o,
  output logic               zero_o
);

  logic [LIVES_W-1:0] count_q;
  logic [LIVES_W-1:0] count_d;

  // next count: decrement only while above zero
  always_comb begin
    count_d = count_q;
    if (dec_i && (count_q != {LIVES_W{1'b0}})) begin
      count_d = count_q - LIVES_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count register with synchronous load
  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      count_q <= LIVES_W'(INIT_LIVES);
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == {LIVES_W{1'b0}});

endmodule

// File: rtl/asteroid_field_engine.sv
// Multi-channel asteroid field: per-channel position/velocity, a frame FSM
// that steps every channel in X then Y, ship collision check and lives.
module asteroid_field_engine
  import asteroid_pkg::*;
#(
  parameter int NUM_AST    = 4,
  parameter int COORD_W    = 4,
  parameter int LIVES_W    = 2,
  parameter int INIT_LIVES = 3,
  parameter int SHIP_X     = 7,
  parameter int SHIP_Y     = 7,
  localparam int IDX_W     = (NUM_AST > 1) ? $clog2(NUM_AST) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       spawn_en,
  input  logic [IDX_W-1:0]           spawn_idx,
  input  logic [COORD_W-1:0]         spawn_x,
  input  logic [COORD_W-1:0]         spawn_y,
  input  logic [3:0]                 spawn_vel,
  input  logic                       kill_en,
  input  logic [IDX_W-1:0]           kill_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       colisao,
  output logic [IDX_W-1:0]           hit_idx,
  output logic [NUM_AST*COORD_W-1:0] ast_x,
  output logic [NUM_AST*COORD_W-1:0] ast_y,
  output logic [NUM_AST-1:0]         ast_active,
  output logic [LIVES_W-1:0]         db_num_vidas,
  output logic                       vidas
);

  localparam logic [IDX_W-1:0]   LAST_CH = IDX_W'(NUM_AST - 1);
  localparam logic [COORD_W-1:0] SHIP_XC = COORD_W'(SHIP_X);
  localparam logic [COORD_W-1:0] SHIP_YC = COORD_W'(SHIP_Y);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ch_q, ch_d;
  logic [COORD_W-1:0]   x_q [NUM_AST];
  logic [COORD_W-1:0]   x_d [NUM_AST];
  logic [COORD_W-1:0]   y_q [NUM_AST];
  logic [COORD_W-1:0]   y_d [NUM_AST];
  logic [3:0]           vel_q [NUM_AST];
  logic [3:0]           vel_d [NUM_AST];
  logic [NUM_AST-1:0]   act_q, act_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 col_q, col_d;
  logic [IDX_W-1:0]     hit_q, hit_d;
  logic                 dec_s;
  logic                 zero_s;

  function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c,
                                                    input logic sub,
                                                    input logic spd);
    logic [COORD_W-1:0] d;
    d = spd ? COORD_W'(STEP_LARGE) : COORD_W'(STEP_SMALL);
    return sub ? (c - d) : (c + d);
  endfunction

  // frame FSM next state, channel updates and event outputs
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    x_d     = x_q;
    y_d     = y_q;
    vel_d   = vel_q;
    act_d   = act_q;
    done_d  = 1'b0;
    col_d   = 1'b0;
    hit_d   = hit_q;
    dec_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // kill first so that a spawn to the same channel overrides it
        if (kill_en && (int'(kill_idx) < NUM_AST)) begin
          act_d[kill_idx] = 1'b0;
        end else begin
          act_d = act_d;
        end
        if (spawn_en && (int'(spawn_idx) < NUM_AST)) begin
          x_d[spawn_idx]   = spawn_x;
          y_d[spawn_idx]   = spawn_y;
          vel_d[spawn_idx] = spawn_vel;
          act_d[spawn_idx] = 1'b1;
        end else begin
          act_d = act_d;
        end
        if (start) begin
          state_d = ST_UPD_X;
          ch_d    = {IDX_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPD_X: begin
        if (act_q[ch_q]) begin
          x_d[ch_q] = step_coord(x_q[ch_q], vel_q[ch_q][VEL_SUB_X], vel_q[ch_q][VEL_SPD_X]);
        end else begin
          x_d[ch_q] = x_q[ch_q];
        end
        state_d = ST_UPD_Y;
      end
      ST_UPD_Y: begin
        if (act_q[ch_q]) begin
          y_d[ch_q] = step_coord(y_q[ch_q], vel_q[ch_q][VEL_SUB_Y], vel_q[ch_q][VEL_SPD_Y]);
        end else begin
          y_d[ch_q] = y_q[ch_q];
        end
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (act_q[ch_q] && (x_q[ch_q] == SHIP_XC) && (y_q[ch_q] == SHIP_YC)) begin
          act_d[ch_q] = 1'b0;
          col_d       = 1'b1;
          hit_d       = ch_q;
          dec_s       = 1'b1;
        end else begin
          col_d = 1'b0;
        end
        ch_d = ch_q + IDX_W'(1);
        if (ch_q == LAST_CH) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_UPD_X;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // state, channel registers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ch_q    <= {IDX_W{1'b0}};
      for (int i = 0; i < NUM_AST; i++) begin
        x_q[i]   <= {COORD_W{1'b0}};
        y_q[i]   <= {COORD_W{1'b0}};
        vel_q[i] <= 4'd0;
      end
      act_q  <= {NUM_AST{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
      col_q  <= 1'b0;
      hit_q  <= {IDX_W{1'b0}};
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      col_q   <= col_d;
      hit_q   <= hit_d;
    end
  end

  lives_counter #(
    .LIVES_W   (LIVES_W),
    .INIT_LIVES(INIT_LIVES)
  ) u_lives (
    .clock_i(clock),
    .clear_i(reset),
    .dec_i  (dec_s),
    .count_o(db_num_vidas),
    .zero_o (zero_s)
  );

  // flatten channel positions onto the output buses
  always_comb begin
    ast_x = {NUM_AST*COORD_W{1'b0}};
    ast_y = {NUM_AST*COORD_W{1'b0}};
    for (int i = 0; i < NUM_AST; i++) begin
      ast_x[i*COORD_W +: COORD_W] = x_q[i];
      ast_y[i*COORD_W +: COORD_W] = y_q[i];
    end
  end

  assign ast_active = act_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign colisao    = col_q;
  assign hit_idx    = hit_q;
  assign vidas      = zero_s;

endmodule

// File: tb/tb_asteroid_field_engine.sv
// Self-checking bench for asteroid_field_engine against a frame-level model.
module tb_asteroid_field_engine;

  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, spawn_en = 1'b0, kill_en = 1'b0;
  logic [1:0]  spawn_idx = 2'd0, kill_idx = 2'd0;
  logic [3:0]  spawn_x = 4'd0, spawn_y = 4'd0, spawn_vel = 4'd0;
  logic        busy, done, colisao, vidas;
  logic [1:0]  hit_idx, db_num_vidas;
  logic [15:0] ast_x, ast_y;
  logic [3:0]  ast_active;

  asteroid_field_engine dut (
    .clock(clock), .reset(reset), .start(start),
    .spawn_en(spawn_en), .spawn_idx(spawn_idx), .spawn_x(spawn_x),
    .spawn_y(spawn_y), .spawn_vel(spawn_vel),
    .kill_en(kill_en), .kill_idx(kill_idx),
    .busy(busy), .done(done), .colisao(colisao), .hit_idx(hit_idx),
    .ast_x(ast_x), .ast_y(ast_y), .ast_active(ast_active),
    .db_num_vidas(db_num_vidas), .vidas(vidas)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // frame-level model
  int mx[N], my[N], mv[N];
  bit ma[N];
  int mlives, mhit;
  bit exp_col[0:63];

  function automatic int wrap16(int v);
    return ((v % 16) + 16) % 16;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; mv[i] = 0; ma[i] = 1'b0;
    end
    mlives = 3;
    mhit   = 0;
  endfunction

  function automatic void model_spawn(int i, int x, int y, int v);
    mx[i] = x; my[i] = y; mv[i] = v; ma[i] = 1'b1;
  endfunction

  // one frame: move every live asteroid, then test it against the ship at (7,7)
  function automatic void model_frame();
    int dx, dy;
    for (int c = 0; c < 64; c++) exp_col[c] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ma[i]) begin
        dx = ((mv[i] >> 2) & 1) ? 2 : 1;
        if ((mv[i] >> 3) & 1) dx = -dx;
        dy = (mv[i] & 1) ? 2 : 1;
        if ((mv[i] >> 1) & 1) dy = -dy;
        mx[i] = wrap16(mx[i] + dx);
        my[i] = wrap16(my[i] + dy);
        if (mx[i] == 7 && my[i] == 7) begin
          ma[i] = 1'b0;
          mhit  = i;
          if (mlives > 0) mlives = mlives - 1;
          exp_col[3*i + 4] = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [15:0] pack_x();
    logic [15:0] r;
    for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'(mx[i]);
    return r;
  endfunction

  function automatic logic [15:0] pack_y();
    logic [15:0] r;
    for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'(my[i]);
    return r;
  endfunction

  function automatic logic [3:0] pack_a();
    logic [3:0] r;
    for (int i = 0; i < N; i++) r[i] = ma[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; spawn_en = 1'b0; kill_en = 1'b0;
  endtask

  // one IDLE cycle carrying an optional spawn and/or kill
  task automatic idle_op(input bit sp, input int si, input int sx, input int sy, input int sv,
                         input bit kl, input int ki);
    spawn_en = sp; spawn_idx = 2'(si); spawn_x = 4'(sx); spawn_y = 4'(sy); spawn_vel = 4'(sv);
    kill_en = kl; kill_idx = 2'(ki);
    tick();
    idle_inputs();
    if (kl) ma[ki] = 1'b0;
    if (sp) model_spawn(si, sx, sy, sv);
  endtask

  // start a frame (any spawn inputs already driven ride along) and observe it
  task automatic run_frame(input bit noise, output int done_cyc, output int n_done,
                           output int bad_col, output int bad_busy);
    model_frame();
    start = 1'b1;
    tick();
    idle_inputs();
    done_cyc = -1; n_done = 0; bad_col = 0; bad_busy = 0;
    for (int c = 1; c <= 20; c++) begin
      if (noise && c >= 2 && c <= 9) begin
        start = 1'($urandom); spawn_en = 1'($urandom); kill_en = 1'($urandom);
        spawn_idx = 2'($urandom); kill_idx = 2'($urandom);
        spawn_x = 4'($urandom); spawn_y = 4'($urandom); spawn_vel = 4'($urandom);
      end else begin
        idle_inputs();
      end
      if (done === 1'b1) begin
        n_done++;
        done_cyc = c;
      end
      if (colisao !== exp_col[c]) bad_col++;
      if (busy !== ((c <= 13) ? 1'b1 : 1'b0)) bad_busy++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    tick(); tick(); tick();
    n_tests++;
    if (db_num_vidas !== 2'd3) begin n_fail++; $display("FAIL reset_lives got %0d want 3", db_num_vidas); end
    n_tests++;
    if (ast_active !== 4'b0000) begin n_fail++; $display("FAIL reset_active got %b want 0000", ast_active); end
    n_tests++;
    if ({vidas, busy, done, colisao} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {vidas, busy, done, colisao});
    end
    n_tests++;
    if ({ast_x, ast_y, hit_idx} !== 34'd0) begin n_fail++; $display("FAIL reset_pos got %h/%h/%0d want 0", ast_x, ast_y, hit_idx); end
  endtask

  task automatic test_basic();
    int dc, nd, bc, bb;
    idle_op(1'b1, 0, 5, 5, 0, 1'b0, 0);
    for (int f = 0; f < 2; f++) begin
      run_frame(1'b0, dc, nd, bc, bb);
      n_tests++;
      if (dc !== 13 || nd !== 1) begin n_fail++; $display("FAIL basic_done f%0d got cyc %0d cnt %0d want 13/1", f, dc, nd); end
      n_tests++;
      if (bc !== 0 || bb !== 0) begin n_fail++; $display("FAIL basic_timing f%0d col_err %0d busy_err %0d want 0", f, bc, bb); end
      n_tests++;
      if (ast_x !== pack_x() || ast_y !== pack_y()) begin
        n_fail++; $display("FAIL basic_pos f%0d got %h/%h want %h/%h", f, ast_x, ast_y, pack_x(), pack_y());
      end
    end
    n_tests++;
    if (ast_active !== 4'b0000 || hit_idx !== 2'd0 || db_num_vidas !== 2'd2) begin
      n_fail++; $display("FAIL basic_hit got act %b hit %0d lives %0d want 0000/0/2", ast_active, hit_idx, db_num_vidas);
    end
  endtask

  task automatic test_wrap_random();
    int dc, nd, bc, bb;
    idle_op(1'b1, 1, 15, 14, 4'b0101, 1'b0, 0);
    run_frame(1'b0, dc, nd, bc, bb);
    n_tests++;
    if (ast_x[7:4] !== 4'd1 || ast_y[7:4] !== 4'd0 || bc !== 0) begin
      n_fail++; $display("FAIL wrap_add got (%0d,%0d) col_err %0d want (1,0)", ast_x[7:4], ast_y[7:4], bc);
    end
    idle_op(1'b1, 2, 0, 1, 4'b1111, 1'b0, 0);
    run_frame(1'b0, dc, nd, bc, bb);
    n_tests++;
    if (ast_x[11:8] !== 4'd14 || ast_y[11:8] !== 4'd15) begin
      n_fail++; $display("FAIL wrap_sub got (%0d,%0d) want (14,15)", ast_x[11:8], ast_y[11:8]);
    end
    for (int f = 0; f < 8; f++) begin
      idle_op(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
      run_frame(1'b0, dc, nd, bc, bb);
      n_tests++;
      if (ast_x !== pack_x() || ast_y !== pack_y() || ast_active !== pack_a()
          || db_num_vidas !== 2'(mlives) || hit_idx !== 2'(mhit) || bc !== 0 || nd !== 1) begin
        n_fail++;
        $display("FAIL random_frame %0d got %h/%h act %b lives %0d hit %0d colerr %0d want %h/%h act %b lives %0d hit %0d",
                 f, ast_x, ast_y, ast_active, db_num_vidas, hit_idx, bc, pack_x(), pack_y(), pack_a(), mlives, mhit);
      end
    end
  endtask

  task automatic test_saturation();
    int dc, nd, bc, bb;
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) idle_op(1'b1, i, 6 - i, 6 - i, 0, 1'b0, 0);
    for (int f = 0; f < 4; f++) begin
      run_frame(1'b0, dc, nd, bc, bb);
      n_tests++;
      if (db_num_vidas !== 2'(mlives) || vidas !== (mlives == 0) || hit_idx !== 2'(f) || bc !== 0) begin
        n_fail++;
        $display("FAIL saturation f%0d got lives %0d vidas %b hit %0d colerr %0d want lives %0d hit %0d",
                 f, db_num_vidas, vidas, hit_idx, bc, mlives, f);
      end
    end
    n_tests++;
    if (db_num_vidas !== 2'd0 || vidas !== 1'b1 || ast_active !== 4'b0000) begin
      n_fail++; $display("FAIL saturation_end got lives %0d vidas %b act %b want 0/1/0000", db_num_vidas, vidas, ast_active);
    end
  endtask

  task automatic test_contention();
    int dc, nd, bc, bb;
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    idle_op(1'b1, 0, 2, 9, 4'b0010, 1'b0, 0);
    idle_op(1'b1, 1, 12, 3, 4'b1000, 1'b0, 0);
    run_frame(1'b1, dc, nd, bc, bb);
    n_tests++;
    if (nd !== 1 || dc !== 13 || bb !== 0) begin n_fail++; $display("FAIL busy_ignore_done got cnt %0d cyc %0d busyerr %0d want 1/13/0", nd, dc, bb); end
    n_tests++;
    if (ast_x !== pack_x() || ast_y !== pack_y() || ast_active !== pack_a()) begin
      n_fail++; $display("FAIL busy_ignore_state got %h/%h %b want %h/%h %b", ast_x, ast_y, ast_active, pack_x(), pack_y(), pack_a());
    end
    idle_op(1'b1, 3, 10, 11, 4'b0110, 1'b1, 3);
    n_tests++;
    if (ast_active[3] !== 1'b1 || ast_x[15:12] !== 4'd10 || ast_y[15:12] !== 4'd11) begin
      n_fail++; $display("FAIL spawn_kill_same got act %b pos (%0d,%0d) want 1 (10,11)", ast_active[3], ast_x[15:12], ast_y[15:12]);
    end
    idle_op(1'b1, 2, 4, 4, 4'b0000, 1'b1, 1);
    n_tests++;
    if (ast_active !== pack_a()) begin n_fail++; $display("FAIL spawn_kill_diff got %b want %b", ast_active, pack_a()); end
    spawn_en = 1'b1; spawn_idx = 2'd1; spawn_x = 4'd8; spawn_y = 4'd0; spawn_vel = 4'b1011;
    model_spawn(1, 8, 0, 4'b1011);
    run_frame(1'b0, dc, nd, bc, bb);
    n_tests++;
    if (ast_x !== pack_x() || ast_y !== pack_y() || ast_active !== pack_a() || bc !== 0) begin
      n_fail++; $display("FAIL spawn_with_start got %h/%h %b want %h/%h %b", ast_x, ast_y, ast_active, pack_x(), pack_y(), pack_a());
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    idle_op(1'b1, 0, 3, 3, 0, 1'b0, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    model_reset();
    n_tests++;
    if (busy !== 1'b0 || ast_x !== 16'd0 || ast_y !== 16'd0 || db_num_vidas !== 2'd3 || ast_active !== 4'd0) begin
      n_fail++; $display("FAIL reset_mid got busy %b %h/%h lives %0d act %b want 0 0/0 3 0000", busy, ast_x, ast_y, db_num_vidas, ast_active);
    end
    nd = 0;
    for (int c = 0; c < 16; c++) begin
      if (done === 1'b1 || busy === 1'b1) nd++;
      tick();
    end
    n_tests++;
    if (nd !== 0) begin n_fail++; $display("FAIL reset_mid_quiet got %0d active cycles want 0", nd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap_random();
    test_saturation();
    test_contention();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
